// File: rtl/submatrix_scan_controller.sv
// submatrix_scan_controller
//   Walks an IMG_W x IMG_H 1-bit image ROM in non-overlapping 4x4 tiles
//   (tile row-major), issues 16 ROM reads per tile, absorbs the 1-cycle
//   ROM latency and packs each tile into a 16-bit word that is handed
//   downstream over a valid/ready handshake.
// Ports
//   clock, resetN   rising-edge clock, synchronous active-low reset
//   start           begin a full image scan (only honoured in IDLE)
//   romAddress      registered ROM address
//   romData         ROM output, valid one cycle after the address is sampled
//   tileValid/Ready downstream handshake for tileElements
//   tileElements    pixel (r,c) at bit 15-(4r+c)
//   tileRow/Col     index of the tile being fetched / presented
//   busy            high whenever not IDLE
//   done            one-cycle pulse after the last tile is accepted
module submatrix_scan_controller #(
   parameter int unsigned IMG_W  = 16,
   parameter int unsigned IMG_H  = 16,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned TIDX_W = 8
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              start,
   output logic [ADDR_W-1:0] romAddress,
   input  logic              romData,
   output logic              tileValid,
   input  logic              tileReady,
   output logic [15:0]       tileElements,
   output logic [TIDX_W-1:0] tileRow,
   output logic [TIDX_W-1:0] tileCol,
   output logic              busy,
   output logic              done
);

   localparam int unsigned TILES_X = IMG_W / 4;
   localparam int unsigned TILES_Y = IMG_H / 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state, state_d;
   logic [3:0]          k, k_d;
   logic [TIDX_W-1:0]   row_d, col_d;
   logic [ADDR_W-1:0]   addr_d;
   // issue_v: romAddress holds a fresh read this cycle (element index = k)
   // read_v : romData holds the pixel for element read_k this cycle
   logic                issue_v, issue_v_d;
   logic                read_v;
   logic [3:0]          read_k;
   logic                last_col_c, last_tile_c;

   // ROM address of element kk inside tile (trow, tcol)
   function automatic logic [ADDR_W-1:0] tile_addr(input logic [TIDX_W-1:0] trow,
                                                   input logic [TIDX_W-1:0] tcol,
                                                   input logic [3:0]        kk);
      return ((ADDR_W'(trow) << 2) + ADDR_W'(kk[3:2])) * ADDR_W'(IMG_W)
             + (ADDR_W'(tcol) << 2) + ADDR_W'(kk[1:0]);
   endfunction

   assign last_col_c  = (tileCol == TIDX_W'(TILES_X - 1));
   assign last_tile_c = last_col_c && (tileRow == TIDX_W'(TILES_Y - 1));

   // Next-state and next-value logic
   always_comb begin
      state_d   = state;
      k_d       = k;
      row_d     = tileRow;
      col_d     = tileCol;
      addr_d    = romAddress;
      issue_v_d = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               k_d       = 4'd0;
               row_d     = '0;
               col_d     = '0;
               addr_d    = tile_addr('0, '0, 4'd0);
               issue_v_d = 1'b1;
            end
         end
         S_FETCH: begin
            if (k == 4'd15) begin
               state_d = S_DRAIN;
            end else begin
               k_d       = k + 4'd1;
               addr_d    = tile_addr(tileRow, tileCol, k + 4'd1);
               issue_v_d = 1'b1;
            end
         end
         S_DRAIN: state_d = S_HOLD;
         S_HOLD: begin
            if (tileReady) begin
               if (last_tile_c) begin
                  state_d = S_DONE;
               end else begin
                  if (last_col_c) begin
                     col_d = '0;
                     row_d = tileRow + TIDX_W'(1);
                  end else begin
                     col_d = tileCol + TIDX_W'(1);
                  end
                  state_d   = S_FETCH;
                  k_d       = 4'd0;
                  addr_d    = tile_addr(row_d, col_d, 4'd0);
                  issue_v_d = 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters, capture pipeline and registered outputs
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state        <= S_IDLE;
         k            <= 4'd0;
         tileRow      <= '0;
         tileCol      <= '0;
         romAddress   <= '0;
         issue_v      <= 1'b0;
         read_v       <= 1'b0;
         read_k       <= 4'd0;
         tileElements <= 16'd0;
         tileValid    <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state      <= state_d;
         k          <= k_d;
         tileRow    <= row_d;
         tileCol    <= col_d;
         romAddress <= addr_d;
         issue_v    <= issue_v_d;
         // element index follows its address through the ROM latency
         read_v     <= issue_v;
         read_k     <= k;
         if (read_v && (state != S_IDLE)) begin
            tileElements[4'd15 - read_k] <= romData;
         end
         tileValid <= (state_d == S_HOLD);
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_submatrix_scan_controller.sv
// Testbench for submatrix_scan_controller: a 12x8 and a 4x4 instance,
// each fed by a ROM model; scans are launched with random, checkerboard
// and address-parity images. Expected addresses and tiles are queued at
// launch; a negedge monitor tracks cycles since start/accept and compares.
module tb_submatrix_scan_controller;

   localparam int unsigned W0 = 12, H0 = 8, W1 = 4, H1 = 4;
   localparam int unsigned AW = 16, TW = 8;

   logic          clock  = 1'b0;
   logic          resetN = 1'b0;
   logic          start       [2];
   logic          start_main  [2] = '{1'b0, 1'b0};
   logic          start_junk  [2] = '{1'b0, 1'b0};
   logic [AW-1:0] rom_address [2];
   logic          rom_data    [2];
   logic          tile_valid  [2];
   logic          tile_ready  [2] = '{1'b0, 1'b0};
   logic [15:0]   tile_elements [2];
   logic [TW-1:0] tile_row    [2];
   logic [TW-1:0] tile_col    [2];
   logic          busy        [2];
   logic          done        [2];

   bit            rom_mem     [2][256];
   int            ready_mode  [2] = '{0, 0};
   bit            junk_en     [2] = '{1'b0, 1'b0};
   int            const_chk   [2] = '{0, 0};

   // expected-response queues (array + read/write pointers)
   int            exp_addr [2][2048];
   logic [15:0]   exp_elem [2][128];
   int            exp_row  [2][128];
   int            exp_col  [2][128];
   int            ap_wr [2] = '{0, 0};
   int            ap_rd [2] = '{0, 0};
   int            tp_wr [2] = '{0, 0};
   int            tp_rd [2] = '{0, 0};
   int            last_addr [2] = '{0, 0};

   // model phase: -1 idle, -2 done cycle, n>=0 edges since start/accept
   int            cnt [2] = '{-1, -1};
   logic          rst_prev = 1'b0;

   int            checks = 0;
   int            passed = 0;

   assign start[0] = start_main[0] | start_junk[0];
   assign start[1] = start_main[1] | start_junk[1];

   always #5 clock = ~clock;

   submatrix_scan_controller #(.IMG_W(W0), .IMG_H(H0), .ADDR_W(AW), .TIDX_W(TW)) u0 (
      .clock(clock), .resetN(resetN), .start(start[0]), .romAddress(rom_address[0]),
      .romData(rom_data[0]), .tileValid(tile_valid[0]), .tileReady(tile_ready[0]),
      .tileElements(tile_elements[0]), .tileRow(tile_row[0]), .tileCol(tile_col[0]),
      .busy(busy[0]), .done(done[0]));

   submatrix_scan_controller #(.IMG_W(W1), .IMG_H(H1), .ADDR_W(AW), .TIDX_W(TW)) u1 (
      .clock(clock), .resetN(resetN), .start(start[1]), .romAddress(rom_address[1]),
      .romData(rom_data[1]), .tileValid(tile_valid[1]), .tileReady(tile_ready[1]),
      .tileElements(tile_elements[1]), .tileRow(tile_row[1]), .tileCol(tile_col[1]),
      .busy(busy[1]), .done(done[1]));

   // ROM models: one cycle read latency
   always @(posedge clock) begin
      rom_data[0] <= rom_mem[0][rom_address[0][7:0]];
      rom_data[1] <= rom_mem[1][rom_address[1][7:0]];
   end

   function automatic int img_w(input int d);
      return (d == 0) ? int'(W0) : int'(W1);
   endfunction

   function automatic int img_h(input int d);
      return (d == 0) ? int'(H0) : int'(H1);
   endfunction

   task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL d%0d %s: got %0h expected %0h (t=%0t)", d, name, act, exp, $time);
   endtask

   // ready / spurious-start driver
   always @(posedge clock) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         case (ready_mode[d])
            0:       tile_ready[d] = 1'b1;
            1:       tile_ready[d] = 1'($urandom_range(0, 1));
            default: tile_ready[d] = (cnt[d] >= 27);
         endcase
         start_junk[d] = junk_en[d] && (cnt[d] != -1) && ($urandom_range(0, 3) == 0);
      end
   end

   // monitor: compares DUT outputs against the queued expectations
   always @(negedge clock) begin : mon
      int nxt;
      for (int d = 0; d < 2; d++) begin
         if (!rst_prev) begin
            chk(d, "rst addr",  32'(rom_address[d]), 32'd0);
            chk(d, "rst valid", 32'(tile_valid[d]), 32'd0);
            chk(d, "rst elems", 32'(tile_elements[d]), 32'd0);
            chk(d, "rst row",   32'(tile_row[d]), 32'd0);
            chk(d, "rst col",   32'(tile_col[d]), 32'd0);
            chk(d, "rst busy",  32'(busy[d]), 32'd0);
            chk(d, "rst done",  32'(done[d]), 32'd0);
         end else if (cnt[d] == -1) begin
            chk(d, "idle busy",  32'(busy[d]), 32'd0);
            chk(d, "idle valid", 32'(tile_valid[d]), 32'd0);
            chk(d, "idle done",  32'(done[d]), 32'd0);
         end else if (cnt[d] == -2) begin
            chk(d, "done pulse", 32'(done[d]), 32'd1);
            chk(d, "done busy",  32'(busy[d]), 32'd1);
            chk(d, "done valid", 32'(tile_valid[d]), 32'd0);
         end else begin
            chk(d, "busy", 32'(busy[d]), 32'd1);
            chk(d, "done low", 32'(done[d]), 32'd0);
            if (tp_rd[d] < tp_wr[d]) begin
               chk(d, "tile row", 32'(tile_row[d]), 32'(exp_row[d][tp_rd[d]]));
               chk(d, "tile col", 32'(tile_col[d]), 32'(exp_col[d][tp_rd[d]]));
            end
            if (cnt[d] <= 15) begin
               chk(d, "fetch valid", 32'(tile_valid[d]), 32'd0);
               if (ap_rd[d] < ap_wr[d]) begin
                  chk(d, "rom addr", 32'(rom_address[d]), 32'(exp_addr[d][ap_rd[d]]));
                  last_addr[d] = exp_addr[d][ap_rd[d]];
                  ap_rd[d]++;
               end else begin
                  checks++;
                  $display("FAIL d%0d addr queue empty: got %0h", d, rom_address[d]);
               end
            end else if (cnt[d] == 16) begin
               chk(d, "drain valid", 32'(tile_valid[d]), 32'd0);
            end else begin
               chk(d, "hold valid", 32'(tile_valid[d]), 32'd1);
               chk(d, "hold addr", 32'(rom_address[d]), 32'(last_addr[d]));
               if (tp_rd[d] < tp_wr[d])
                  chk(d, "tile elems", 32'(tile_elements[d]), 32'(exp_elem[d][tp_rd[d]]));
               if (tile_ready[d] && const_chk[d] == 1)
                  chk(d, "checker tile", 32'(tile_elements[d]), 32'h5A5A);
               if (tile_ready[d] && const_chk[d] == 2)
                  chk(d, "parity tile", 32'(tile_elements[d]), 32'h5555);
            end
         end

         // advance the model to the state after the coming edge
         if (!resetN) begin
            nxt = -1;
            ap_rd[d] = ap_wr[d];
            tp_rd[d] = tp_wr[d];
         end else if (cnt[d] == -1) begin
            nxt = start[d] ? 0 : -1;
         end else if (cnt[d] == -2) begin
            nxt = -1;
         end else if (cnt[d] >= 17 && tile_ready[d]) begin
            tp_rd[d]++;
            nxt = (tp_rd[d] >= tp_wr[d]) ? -2 : 0;
         end else begin
            nxt = (cnt[d] < 1000) ? cnt[d] + 1 : cnt[d];
         end
         cnt[d] = nxt;
      end
      rst_prev = resetN;
   end

   task automatic wait_idle(input int d);
      int n = 0;
      while (cnt[d] != -1 && n < 5000) begin
         @(posedge clock);
         n++;
      end
      checks++;
      if (cnt[d] == -1) passed++;
      else $display("FAIL d%0d scan timeout: phase %0d expected idle", d, cnt[d]);
   endtask

   // load an image, queue the expected scan, and pulse start for one cycle
   task automatic launch(input int d, input int pat, input int mode);
      int w, h, a;
      logic [15:0] e;
      wait_idle(d);
      @(posedge clock);
      #1;
      w = img_w(d);
      h = img_h(d);
      for (int i = 0; i < 256; i++) begin
         case (pat)
            1:       rom_mem[d][i] = bit'(((i % w) + (i / w)) & 1);
            2:       rom_mem[d][i] = bit'(i & 1);
            default: rom_mem[d][i] = bit'($urandom_range(0, 1));
         endcase
      end
      const_chk[d] = pat;
      for (int ty = 0; ty < h / 4; ty++) begin
         for (int tx = 0; tx < w / 4; tx++) begin
            e = 16'd0;
            for (int k = 0; k < 16; k++) begin
               a = (ty * 4 + k / 4) * w + tx * 4 + (k % 4);
               exp_addr[d][ap_wr[d]] = a;
               ap_wr[d]++;
               e[15 - k] = rom_mem[d][a];
            end
            exp_elem[d][tp_wr[d]] = e;
            exp_row[d][tp_wr[d]]  = ty;
            exp_col[d][tp_wr[d]]  = tx;
            tp_wr[d]++;
         end
      end
      ready_mode[d] = mode;
      start_main[d] = 1'b1;
      @(posedge clock);
      #1;
      start_main[d] = 1'b0;
   endtask

   task automatic scan(input int d, input int pat, input int mode);
      launch(d, pat, mode);
      wait_idle(d);
   endtask

   initial begin
      resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1 resetN = 1'b1;

      scan(0, 1, 0);          // checkerboard, ready held high
      scan(0, 2, 1);          // address-parity image, random ready
      junk_en[0] = 1'b1;      // spurious starts while busy
      scan(0, 0, 2);          // long stalls in HOLD
      scan(0, 0, 1);
      junk_en[0] = 1'b0;

      // reset mid-FETCH for three edges, then rescan from tile (0,0)
      launch(0, 0, 0);
      repeat (5) @(posedge clock);
      #1 resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1 resetN = 1'b1;
      scan(0, 0, 1);

      // single-tile image
      scan(1, 0, 0);
      junk_en[1] = 1'b1;
      scan(1, 1, 2);
      scan(1, 0, 1);
      junk_en[1] = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
